// File: rtl/fmul_feeder_pkg.sv
// fmul_feeder_pkg: shared types and constants for the FP32 multiplier operand feeder.
package fmul_feeder_pkg;

   localparam int FP_W = 32;
   localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_LD_A,
      S_REL_A,
      S_LD_B,
      S_REL_B,
      S_START,
      S_WAIT_RES,
      S_REL_RES
   } state_t;

   typedef struct packed {
      logic [FP_W-1:0] a;
      logic [FP_W-1:0] b;
   } pair_t;

   // Width of a down-counter that must hold the largest of three phase lengths minus one
   function automatic int cnt_width(input int len_a, input int len_b, input int len_c);
      int m;
      m = len_a;
      if (len_b > m) m = len_b;
      if (len_c > m) m = len_c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/fmul_operand_feeder_if.sv
// fmul_operand_feeder_if: operand input, multiplier load/result and product output signals.
// master = the feeder, slave = the surrounding producer/multiplier/consumer.
interface fmul_operand_feeder_if;

   logic                           in_valid;
   logic                           in_ready;
   logic [fmul_feeder_pkg::FP_W-1:0] in_a;
   logic [fmul_feeder_pkg::FP_W-1:0] in_b;
   logic                           mul_clr;
   logic [fmul_feeder_pkg::FP_W-1:0] mul_bus;
   logic                           mul_ready;
   logic                           mul_accept;
   logic                           mul_start;
   logic                           res_ready;
   logic [fmul_feeder_pkg::FP_W-1:0] res_bus;
   logic                           res_accept;
   logic                           out_valid;
   logic                           out_ready;
   logic [fmul_feeder_pkg::FP_W-1:0] out_data;
   logic                           out_err;

   modport master (
      input  in_valid, in_a, in_b, mul_accept, res_ready, res_bus, out_ready,
      output in_ready, mul_clr, mul_bus, mul_ready, mul_start, res_accept,
             out_valid, out_data, out_err
   );

   modport slave (
      output in_valid, in_a, in_b, mul_accept, res_ready, res_bus, out_ready,
      input  in_ready, mul_clr, mul_bus, mul_ready, mul_start, res_accept,
             out_valid, out_data, out_err
   );

endinterface

// File: rtl/fmul_pair_fifo.sv
// fmul_pair_fifo: DEPTH-entry operand-pair FIFO, wrap-bit pointers, registered full/empty.
// A push into a full FIFO is refused even when a pop happens in the same cycle.
module fmul_pair_fifo
   import fmul_feeder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_push,
   input  pair_t i_data,
   input  logic  i_pop,
   output pair_t o_data,
   output logic  o_full,
   output logic  o_empty
);
   localparam int AW = $clog2(DEPTH);

   pair_t       r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_full;
   logic        r_empty;
   logic [AW:0] w_wr_nxt;
   logic [AW:0] w_rd_nxt;
   logic        w_push_ok;
   logic        w_pop_ok;

   assign w_push_ok = i_push && !r_full;
   assign w_pop_ok  = i_pop && !r_empty;
   assign w_wr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
   assign w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full    = r_full;
   assign o_empty   = r_empty;

   // Storage write; contents need no reset since empty gates every read
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   // Pointers and flags computed from the next pointer values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_full   <= (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);
         r_empty  <= (w_wr_nxt == w_rd_nxt);
      end
   end

endmodule

// File: rtl/fmul_operand_feeder.sv
// fmul_operand_feeder: buffers FP32 operand pairs, clears the multiplier, loads A then B
// over a four-phase word handshake, starts it and returns the product on a valid/ready port.
// Build option FMUL_FEEDER_TIMEOUT_EN: watchdog over WAIT_RES/REL_RES that returns qNaN
// with out_err=1 after TIMEOUT cycles; without it out_err is tied low.
//
// state      | meaning
// S_IDLE     | wait for a buffered pair and a drained output
// S_CLR      | mul_clr high for CLR_CYCLES
// S_LD_A     | A on mul_bus, mul_ready high until mul_accept
// S_REL_A    | A held, wait for mul_accept low
// S_LD_B     | B on mul_bus, mul_ready high until mul_accept
// S_REL_B    | B held, wait for mul_accept low
// S_START    | mul_start high for START_CYCLES
// S_WAIT_RES | wait for res_ready, capture res_bus
// S_REL_RES  | res_accept high until res_ready low
module fmul_operand_feeder
   import fmul_feeder_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int CLR_CYCLES   = 2,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 64
) (
   input logic                   clk,
   input logic                   rst_n,
   fmul_operand_feeder_if.master ifc
);
   localparam int CNT_W = cnt_width(CLR_CYCLES, START_CYCLES, TIMEOUT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_tc;
   logic             w_tmo;
   logic             w_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   pair_t            w_in_pair;
   pair_t            w_fifo_pair;
   logic [FP_W-1:0]  r_a;
   logic [FP_W-1:0]  r_b;
   logic [FP_W-1:0]  r_out_data;
   logic             r_out_valid;

   assign w_in_pair     = '{a: ifc.in_a, b: ifc.in_b};
   assign w_cnt_tc      = (r_cnt == '0);
   assign w_pop         = (r_state == S_IDLE) && !w_fifo_empty && !r_out_valid;
   assign ifc.in_ready  = !w_fifo_full;
   assign ifc.out_valid = r_out_valid;
   assign ifc.out_data  = r_out_data;

   fmul_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (ifc.in_valid),
      .i_data  (w_in_pair),
      .i_pop   (w_pop),
      .o_data  (w_fifo_pair),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; the watchdog overrides the result handshake
   always_comb begin
      w_state_nxt = r_state;
      w_tmo       = 1'b0;
      case (r_state)
         S_IDLE:     if (w_pop)            w_state_nxt = S_CLR;
         S_CLR:      if (w_cnt_tc)         w_state_nxt = S_LD_A;
         S_LD_A:     if (ifc.mul_accept)   w_state_nxt = S_REL_A;
         S_REL_A:    if (!ifc.mul_accept)  w_state_nxt = S_LD_B;
         S_LD_B:     if (ifc.mul_accept)   w_state_nxt = S_REL_B;
         S_REL_B:    if (!ifc.mul_accept)  w_state_nxt = S_START;
         S_START:    if (w_cnt_tc)         w_state_nxt = S_WAIT_RES;
         S_WAIT_RES: if (ifc.res_ready)    w_state_nxt = S_REL_RES;
         S_REL_RES:  if (!ifc.res_ready)   w_state_nxt = S_IDLE;
         default:                          w_state_nxt = S_IDLE;
      endcase
`ifdef FMUL_FEEDER_TIMEOUT_EN
      if ((r_state == S_WAIT_RES || r_state == S_REL_RES) && w_cnt_tc) begin
         w_tmo       = 1'b1;
         w_state_nxt = S_IDLE;
      end
`endif
   end

   // Multiplier-side outputs decoded from the current state
   always_comb begin
      ifc.mul_clr    = (r_state == S_CLR);
      ifc.mul_ready  = (r_state == S_LD_A) || (r_state == S_LD_B);
      ifc.mul_start  = (r_state == S_START);
      ifc.res_accept = (r_state == S_REL_RES);
      ifc.mul_bus    = '0;
      case (r_state)
         S_LD_A, S_REL_A: ifc.mul_bus = r_a;
         S_LD_B, S_REL_B: ifc.mul_bus = r_b;
         default:         ifc.mul_bus = '0;
      endcase
   end

   // Shared phase down-counter: CLR and START lengths, and the result watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == S_IDLE && w_state_nxt == S_CLR) begin
         r_cnt <= CNT_W'(CLR_CYCLES - 1);
      end else if (r_state == S_REL_B && w_state_nxt == S_START) begin
         r_cnt <= CNT_W'(START_CYCLES - 1);
`ifdef FMUL_FEEDER_TIMEOUT_EN
      end else if (r_state == S_START && w_state_nxt == S_WAIT_RES) begin
         r_cnt <= CNT_W'(TIMEOUT - 1);
`endif
      end else if (!w_cnt_tc) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Operand capture on pop, product capture and output valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_pop) begin
            r_a <= w_fifo_pair.a;
            r_b <= w_fifo_pair.b;
         end
         if (w_tmo)                                     r_out_data <= QNAN;
         else if (r_state == S_WAIT_RES && ifc.res_ready) r_out_data <= ifc.res_bus;
         if (w_tmo || (r_state == S_REL_RES && !ifc.res_ready)) r_out_valid <= 1'b1;
         else if (r_out_valid && ifc.out_ready)                 r_out_valid <= 1'b0;
      end
   end

`ifdef FMUL_FEEDER_TIMEOUT_EN
   logic r_out_err;

   // Error flag travels with the timed-out product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_out_err <= 1'b0;
      else if (w_tmo)                        r_out_err <= 1'b1;
      else if (r_out_valid && ifc.out_ready) r_out_err <= 1'b0;
   end

   assign ifc.out_err = r_out_err;
`else
   assign ifc.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fmul_operand_feeder.sv
// tb_fmul_operand_feeder: scoreboard bench with a handshake-accurate multiplier model.
module tb_fmul_operand_feeder;
   import fmul_feeder_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   fmul_operand_feeder_if ifc();

   fmul_operand_feeder #(
      .DEPTH(4), .CLR_CYCLES(2), .START_CYCLES(2), .TIMEOUT(64)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ifc   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] wq[2];
   int          wi, hold, hold_a_extra, hold_cycles, hold_bad;
   int          clr_run, last_clr, lat;
   logic        block_b, no_result, pend, start_seen;

   logic [31:0] t3a[5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000, 32'h3FC00000};
   logic [31:0] t3b[5] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h40800000, 32'h3FC00000};
   logic [31:0] t3p[5] = '{32'h40000000, 32'h40800000, 32'h3FC00000, 32'hC0800000, 32'h40100000};

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
      else n_pass++;
   endtask

   // Truncating FP32 multiply for normal operands, used by the multiplier model
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   // Multiplier model: word handshake, clear pulse measurement, fixed-latency result
   initial begin
      ifc.mul_accept = 1'b0; ifc.res_ready = 1'b0; ifc.res_bus = '0;
      wi = 0; hold = 0; hold_cycles = 0; hold_bad = 0; clr_run = 0; last_clr = 0;
      lat = 0; pend = 1'b0; start_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ifc.mul_accept = 1'b0; ifc.res_ready = 1'b0; ifc.res_bus = '0;
            wi = 0; hold = 0; clr_run = 0; pend = 1'b0; start_seen = 1'b0;
         end else begin
            if (ifc.mul_clr) begin
               wi = 0;
               clr_run++;
            end else if (clr_run != 0) begin
               last_clr = clr_run;
               clr_run  = 0;
            end
            if (ifc.mul_accept) begin
               if (hold > 0) begin
                  hold--;
                  hold_cycles++;
                  if (ifc.mul_ready || ifc.mul_bus !== wq[0]) hold_bad++;
               end else if (!ifc.mul_ready) begin
                  ifc.mul_accept = 1'b0;
               end
            end else if (ifc.mul_ready && !(block_b && wi == 1)) begin
               wq[wi] = ifc.mul_bus;
               hold   = (wi == 0) ? hold_a_extra : 0;
               wi     = 1 - wi;
               ifc.mul_accept = 1'b1;
            end
            if (ifc.res_ready) begin
               if (ifc.res_accept) ifc.res_ready = 1'b0;
            end else if (pend) begin
               if (lat == 0) begin
                  pend = 1'b0;
                  if (!no_result) begin
                     ifc.res_bus   = fp_mul(wq[0], wq[1]);
                     ifc.res_ready = 1'b1;
                  end
               end else begin
                  lat--;
               end
            end else if (ifc.mul_start && !start_seen) begin
               pend = 1'b1;
               lat  = 3;
            end
            start_seen = ifc.mul_start;
         end
      end
   end

   // Output monitor: compare each taken product against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               chk("out_data", 64'(ifc.out_data), 64'(e.data));
               chk("out_err", 64'(ifc.out_err), 64'(e.err));
            end
         end
      end
   end

   // Offer one pair (caller sits at a negedge) and hold until accepted
   task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input exp_t e);
      int n;
      n = 0;
      ifc.in_valid = 1'b1; ifc.in_a = a; ifc.in_b = b;
      while (!ifc.in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("push_accepted", 64'(ifc.in_ready), 64'd1);
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(sb.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctrl"}, 64'({ifc.in_ready, ifc.mul_clr, ifc.mul_ready, ifc.mul_start,
                               ifc.res_accept, ifc.out_valid, ifc.out_err}), 64'b1000000);
      chk({tag, "_data"}, {ifc.mul_bus, ifc.out_data}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "time limit");
   end

   initial begin
      int n, busy;
      rst_n = 1'b0; ifc.in_valid = 1'b0; ifc.in_a = '0; ifc.in_b = '0; ifc.out_ready = 1'b1;
      block_b = 1'b0; no_result = 1'b0; hold_a_extra = 0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 12.25 * -3.5
      push_pair(32'h41440000, 32'hC0600000, '{data: 32'hC22B8000, err: 1'b0});
      ifc.in_valid = 1'b0;
      wait_drain("t1_drain");
      chk("t1_clr_len", 64'(last_clr), 64'd2);
      chk("t1_word_a", 64'(wq[0]), 64'h41440000);
      chk("t1_word_b", 64'(wq[1]), 64'hC0600000);

      // 2: 2.25 * 17.5
      push_pair(32'h40100000, 32'h418C0000, '{data: 32'h421D8000, err: 1'b0});
      ifc.in_valid = 1'b0;
      wait_drain("t2_drain");

      // 3: five pairs with the consumer stalled
      ifc.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_pair(t3a[i], t3b[i], '{data: t3p[i], err: 1'b0});
      ifc.in_valid = 1'b0;
      n = 0;
      while (!ifc.out_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("t3_first_valid", 64'(ifc.out_valid), 64'd1);
      busy = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifc.mul_clr || ifc.mul_ready || ifc.mul_start) busy++;
      end
      chk("t3_fifo_full", 64'(ifc.in_ready), 64'd0);
      chk("t3_held_data", 64'(ifc.out_data), 64'h40000000);
      chk("t3_no_new_pair", 64'(busy), 64'd0);
      chk("t3_pending", 64'(sb.size()), 64'd5);
      ifc.out_ready = 1'b1;
      wait_drain("t3_drain");
      chk("t3_in_ready_back", 64'(ifc.in_ready), 64'd1);

      // 4: mul_accept held 3 extra cycles after A
      hold_a_extra = 3; hold_cycles = 0; hold_bad = 0;
      push_pair(32'h40400000, 32'h3F000000, '{data: 32'h3FC00000, err: 1'b0});
      ifc.in_valid = 1'b0;
      wait_drain("t4_drain");
      hold_a_extra = 0;
      chk("t4_hold_cycles", 64'(hold_cycles), 64'd3);
      chk("t4_hold_bus_stable", 64'(hold_bad), 64'd0);

      // 5: reset while B is on the bus
      block_b = 1'b1;
      push_pair(32'h3F800000, 32'h40000000, '{data: 32'h40000000, err: 1'b0});
      ifc.in_valid = 1'b0;
      n = 0;
      while (!(ifc.mul_ready && ifc.mul_bus == 32'h40000000) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t5_in_ld_b", 64'(ifc.mul_ready), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("t5_async_reset");
      sb.delete();
      block_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_pair(32'h40100000, 32'h418C0000, '{data: 32'h421D8000, err: 1'b0});
      ifc.in_valid = 1'b0;
      wait_drain("t5_after_reset");
      chk("t5_clr_len", 64'(last_clr), 64'd2);

`ifdef FMUL_FEEDER_TIMEOUT_EN
      // 6: result never arrives
      no_result = 1'b1;
      push_pair(32'h3F800000, 32'h3F800000, '{data: QNAN, err: 1'b1});
      ifc.in_valid = 1'b0;
      wait_drain("t6_timeout");
      no_result = 1'b0;
      chk("t6_err_cleared", 64'(ifc.out_err), 64'd0);
`endif

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
